rr_counter_arbiter: RTL and testbench

//  - Round-robin arbiter sharing one resource among 4 requesters.
//  - A 2-bit wrap-around priority pointer (0->1->2->3->0) rotates after every completed grant.
//  - Sits between requesting agents and the shared resource; one owner at a time, registered grant.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_ptr_counter.sv | 20 ++
 rtl/rr_counter_arbiter.sv | 84 ++++++++
 tb/tb_rr_counter_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types, constants and the round-robin pick function
// for rr_counter_arbiter.
package arb_pkg;
    localparam int N_REQ    = 4;
    localparam int PTR_W    = 2;
    localparam int MAX_HOLD = 8;
    localparam int HOLD_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Returns {found, idx}; scanning down to offset 0 leaves the highest-priority hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] req, input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0]   r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_ptr_counter.sv
// rr_ptr_counter: 2-bit wrap-around priority pointer; loads base+1 on release,
// asynchronously cleared to 0.
module rr_ptr_counter
    import arb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [PTR_W-1:0] i_base,
    output logic [PTR_W-1:0] o_ptr
);
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ptr <= '0;
        else if (i_load) r_ptr <= i_base + PTR_W'(1);
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/rr_counter_arbiter.sv
// rr_counter_arbiter: 4-way round-robin arbiter with registered one-hot grant.
// Define HOLD_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_counter_arbiter
    import arb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0] o_gnt_id,
    output logic             o_gnt_valid,
    output logic             o_timeout
);
    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [PTR_W-1:0] r_gnt_id;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W:0]   w_pick;
    logic             w_own;
    logic             w_to;
    logic             w_release;

    assign w_pick = rr_pick(i_req, w_ptr);
    assign w_own  = i_req[r_gnt_id];

`ifdef HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_hold <= '0;
        else if (r_state == IDLE && w_pick[PTR_W]) r_hold <= HOLD_W'(1);
        else if (r_state == GRANT) r_hold <= r_hold + HOLD_W'(1);
        else r_hold <= '0;
    end

    // A voluntary drop on the limit edge wins over the forced release.
    assign w_to = r_state == GRANT && w_own && r_hold == HOLD_W'(MAX_HOLD);
`else
    assign w_to = 1'b0;
`endif

    assign w_release = r_state == GRANT && (!w_own || w_to);

    rr_ptr_counter u_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_release),
        .i_base  (r_gnt_id),
        .o_ptr   (w_ptr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_to;
            case (r_state)
                IDLE: if (w_pick[PTR_W]) begin
                    r_state     <= GRANT;
                    r_gnt       <= N_REQ'(1) << w_pick[PTR_W-1:0];
                    r_gnt_id    <= w_pick[PTR_W-1:0];
                    r_gnt_valid <= 1'b1;
                end
                GRANT: if (w_release) begin
                    r_state     <= RELEASE;
                    r_gnt       <= '0;
                    r_gnt_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_id    = r_gnt_id;
    assign o_gnt_valid = r_gnt_valid;
    assign o_timeout   = r_timeout;
endmodule

// File: tb/tb_rr_counter_arbiter.sv
// tb_rr_counter_arbiter: directed checks of rotation, skip/wrap, grant stability,
// async reset and (with HOLD_TIMEOUT_EN) forced release.
module tb_rr_counter_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;

    rr_counter_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .o_gnt       (gnt),
        .o_gnt_id    (gnt_id),
        .o_gnt_valid (gnt_valid),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Owner k holds for `hold` cycles, drops, then req becomes `after` during the dead cycle.
    task automatic serve(input logic [1:0] k, input int hold, input logic [3:0] after);
        step();
        check("rot_gnt", gnt, 4'b0001 << k);
        check("rot_id", gnt_id, k);
        check("rot_valid", gnt_valid, 1);
        repeat (hold - 1) step();
        req[k] = 1'b0;
        step();
        check("dead_gnt", gnt, 0);
        check("dead_valid", gnt_valid, 0);
        req = after;
        step();
        check("idle_gnt", gnt, 0);
    endtask

    initial begin
        int         n;
        logic       tflag;
        logic [3:0] pats [4] = '{4'b0101, 4'b1111, 4'b1100, 4'b0110};
        rst_n = 1'b0;
        req   = 4'hF;
        repeat (2) step();
        check("rst_gnt", gnt, 0);
        check("rst_valid", gnt_valid, 0);
        check("rst_to", timeout, 0);
        check("rst_id", gnt_id, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) serve(2'(i % 4), 3, 4'hF);
        req = 4'b0100;
        step();
        check("stab_gnt", gnt, 4'b0100);
        check("stab_id", gnt_id, 2);
        foreach (pats[i]) begin
            req = pats[i];
            step();
            check("stab_hold", gnt, 4'b0100);
        end
        req = 4'b0000;
        step();
        check("stab_rel", gnt, 0);
        req = 4'b0010;
        step();
        check("wrap_idle", gnt, 0);
        step();
        check("wrap_gnt", gnt, 4'b0010);
        check("wrap_id", gnt_id, 1);
        req = 4'b0000;
        step();
        check("wrap_rel", gnt, 0);
        req = 4'hF;
        step();
        check("wrap_idle2", gnt, 0);
        step();
        check("ptr2_id", gnt_id, 2);
        req = 4'b0010;
        step();
        step();
        step();
        check("pre_rst_gnt", gnt, 4'b0010);
        #1 rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 0);
        check("async_valid", gnt_valid, 0);
        step();
        rst_n = 1'b1;
        req   = 4'b1010;
        step();
        check("restart_gnt", gnt, 4'b0010);
        check("restart_id", gnt_id, 1);
        req = 4'b0000;
        repeat (4) begin
            step();
            check("noreq_gnt", gnt, 0);
        end
        req = 4'b1001;
        step();
        check("noreq_id", gnt_id, 3);
        req = 4'b0001;
        repeat (3) step();
        n     = 0;
        tflag = 1'b0;
        while (gnt == 4'b0001 && n < 20) begin
            n++;
            tflag |= timeout;
            step();
        end
`ifdef HOLD_TIMEOUT_EN
        check("hold_cycles", n, 8);
        check("to_early", tflag, 0);
        check("to_pulse", timeout, 1);
        check("to_gnt", gnt, 0);
        req = 4'b0101;
        step();
        check("to_clear", timeout, 0);
        check("to_idle", gnt, 0);
        step();
        check("evict_gnt", gnt, 4'b0100);
        check("evict_id", gnt_id, 2);
`else
        check("hold_cycles", n, 20);
        check("hold_to", tflag, 0);
        check("hold_gnt", gnt, 4'b0001);
        check("hold_to_now", timeout, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
